// File: rtl/nroot_pkg.sv
// rtl/nroot_pkg.sv - shared states, field struct and IEEE constant helpers for nroot_seq_fp
package nroot_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_EDIV, S_TRIAL, S_MUL, S_CMP, S_PACK, S_DONE
  } state_t;

  // Fields are sized for the widest supported format; users slice to EXP_W/MAN_W.
  localparam int MAX_EXP_W = 15;
  localparam int MAX_MAN_W = 112;
  localparam int MAX_FP_W  = 128;

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp;
    logic [MAX_MAN_W-1:0] frac;
  } fp_fields_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [MAX_FP_W-1:0] fp_nan(input int exp_w, input int man_w);
    return (MAX_FP_W'(1) << (exp_w + man_w)) - MAX_FP_W'(1);
  endfunction

  function automatic logic [MAX_FP_W-1:0] fp_inf(input logic sign, input int exp_w, input int man_w);
    return (MAX_FP_W'(sign) << (exp_w + man_w)) |
           (((MAX_FP_W'(1) << exp_w) - MAX_FP_W'(1)) << man_w);
  endfunction

  function automatic fp_fields_t fp_unpack(input logic [MAX_FP_W-1:0] bits,
                                           input int exp_w, input int man_w);
    fp_fields_t f;
    logic [MAX_FP_W-1:0] emask;
    logic [MAX_FP_W-1:0] mmask;
    emask  = (MAX_FP_W'(1) << exp_w) - MAX_FP_W'(1);
    mmask  = (MAX_FP_W'(1) << man_w) - MAX_FP_W'(1);
    f.sign = |((bits >> (exp_w + man_w)) & MAX_FP_W'(1));
    f.exp  = MAX_EXP_W'((bits >> man_w) & emask);
    f.frac = MAX_MAN_W'(bits & mmask);
    return f;
  endfunction

endpackage

// File: rtl/nroot_exp_div.sv
// rtl/nroot_exp_div.sv - sequential signed floor division of an exponent by k
// Cycles after start: one abs cycle, EW quotient-bit cycles, one fixup cycle (done high).
module nroot_exp_div #(
  parameter int EW = 8,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [EW:0]   e,
  input  logic [KW-1:0] k,
  output logic          done,
  output logic [EW:0]   q,
  output logic [KW-1:0] r
);
  import nroot_pkg::*;

  localparam int CW = $clog2(EW + 2);

  logic          run;
  logic [CW-1:0] cnt;
  logic [EW:0]   e_r;
  logic          neg;
  logic [EW-1:0] mag;
  logic [KW-1:0] rem;
  logic [KW:0]   part;
  logic          fits;

  assign part = {rem, mag[EW-1]};
  assign fits = part >= {1'b0, k};
  assign done = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (start) begin
      run <= 1'b1;
      e_r <= e;
      cnt <= CW'(EW + 1);
    end else if (run) begin
      if (cnt == CW'(EW + 1)) begin
        neg <= e_r[EW];
        mag <= e_r[EW] ? EW'(-e_r) : EW'(e_r);
        rem <= '0;
        cnt <= cnt - 1'b1;
      end else if (cnt != '0) begin
        rem <= fits ? KW'(part - {1'b0, k}) : part[KW-1:0];
        mag <= {mag[EW-2:0], fits};
        cnt <= cnt - 1'b1;
      end else begin
        run <= 1'b0;
      end
    end
  end

  // Negative dividend with a remainder rounds toward -inf: q=-|q|-1, r=k-rem.
  always_comb begin
    q = {1'b0, mag};
    r = rem;
    if (neg && rem != '0) begin
      q = ~{1'b0, mag};
      r = k - rem;
    end else if (neg) begin
      q = (EW + 1)'(0) - {1'b0, mag};
    end
  end

endmodule

// File: rtl/nroot_seq_fp.sv
// rtl/nroot_seq_fp.sv - sequential IEEE n-th root, digit-by-digit with valid/ready handshakes
// Optional NROOT_FLAGS_EN adds out_invalid/out_inexact status ports.
module nroot_seq_fp #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 23,
  parameter int MAX_ROOT = 8,
  parameter int GUARD    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [EXP_W+MAN_W:0]           base,
  input  logic [$clog2(MAX_ROOT+1)-1:0]  root,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_W+MAN_W:0]           out,
`ifdef NROOT_FLAGS_EN
  output logic                           out_invalid,
  output logic                           out_inexact,
`endif
  output logic                           busy
);
  import nroot_pkg::*;

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int KW = $clog2(MAX_ROOT + 1);
  localparam int FW = MAN_W + GUARD;
  localparam int AW = MAX_ROOT + FW;
  localparam int IW = $clog2(MAN_W);
  localparam logic [EXP_W:0]        BIAS_V    = (EXP_W + 1)'(fp_bias(EXP_W));
  localparam logic [KW-1:0]         MAXK      = KW'(MAX_ROOT);
  localparam logic [MAX_FP_W-1:0]   NAN_WIDE  = fp_nan(EXP_W, MAN_W);
  localparam logic [MAX_FP_W-1:0]   PINF_WIDE = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [MAX_FP_W-1:0]   NINF_WIDE = fp_inf(1'b1, EXP_W, MAN_W);
  localparam logic [W-1:0]          NAN_V     = NAN_WIDE[W-1:0];
  localparam logic [W-1:0]          PINF_V    = PINF_WIDE[W-1:0];
  localparam logic [W-1:0]          NINF_V    = NINF_WIDE[W-1:0];

  state_t state, state_nxt;

  logic [W-1:0]       base_r;
  logic [KW-1:0]      k_r;
  logic               spec_r;
  logic [W-1:0]       spec_res;
  logic [AW-1:0]      r_fx;
  logic [AW-1:0]      acc;
  logic [MAN_W:0]     y;
  logic [MAN_W:0]     trial;
  logic [IW-1:0]      idx;
  logic [KW-1:0]      mcnt;
  logic [EXP_W:0]     q_r;

  fp_fields_t         f;
  logic               unused_fields;
  logic               sgn;
  logic [EXP_W-1:0]   ex;
  logic [MAN_W-1:0]   fr;
  logic               is_nan, is_inf, is_zero, bad_k, odd_k;
  logic               special;
  logic [W-1:0]       spec_val;
  logic [EXP_W:0]     e_unb;
  logic [EXP_W-1:0]   e_out;
  logic               div_start, div_done;
  logic [EXP_W:0]     div_q;
  logic [KW-1:0]      div_r;
  logic [AW-1:0]      r_new;
  logic [MAN_W:0]     bitmask;
  logic [AW+MAN_W:0]  prod;
  logic [AW:0]        prod_sh;
  logic               sat;

  assign f             = fp_unpack(MAX_FP_W'(base_r), EXP_W, MAN_W);
  assign unused_fields = &{1'b0, f};
  assign sgn           = f.sign;
  assign ex            = f.exp[EXP_W-1:0];
  assign fr            = f.frac[MAN_W-1:0];
  assign is_nan        = (&ex) && (fr != '0);
  assign is_inf        = (&ex) && (fr == '0);
  assign is_zero       = (ex == '0);
  assign bad_k         = (k_r == '0) || (k_r > MAXK);
  assign odd_k         = k_r[0];
  assign e_unb         = {1'b0, ex} - BIAS_V;
  assign e_out         = EXP_W'(q_r + BIAS_V);
  assign r_new         = AW'({1'b1, fr, {GUARD{1'b0}}}) << div_r;
  assign bitmask       = (MAN_W + 1)'(1) << idx;
  assign prod          = {{(MAN_W+1){1'b0}}, acc} * {{AW{1'b0}}, trial};
  assign prod_sh       = (AW + 1)'(prod >> MAN_W);
  assign sat           = prod_sh > {1'b0, r_fx};
  assign div_start     = (state == S_UNPACK) && !special;

`ifdef NROOT_FLAGS_EN
  logic spec_inv, inv_r, eq_r;
`endif

  always_comb begin
    special  = 1'b1;
    spec_val = '0;
`ifdef NROOT_FLAGS_EN
    spec_inv = 1'b0;
`endif
    if (is_nan || bad_k) begin
      spec_val = NAN_V;
`ifdef NROOT_FLAGS_EN
      spec_inv = !is_nan;
`endif
    end else if (is_inf) begin
      if (sgn && !odd_k) begin
        spec_val = NAN_V;
`ifdef NROOT_FLAGS_EN
        spec_inv = 1'b1;
`endif
      end else begin
        spec_val = sgn ? NINF_V : PINF_V;
      end
    end else if (is_zero) begin
      // Subnormals land here too and flush to a signed zero.
      spec_val = {sgn & odd_k, {(W-1){1'b0}}};
    end else if (sgn && !odd_k) begin
      spec_val = NAN_V;
`ifdef NROOT_FLAGS_EN
      spec_inv = 1'b1;
`endif
    end else if (k_r == KW'(1)) begin
      spec_val = base_r;
    end else begin
      special = 1'b0;
    end
  end

  nroot_exp_div #(.EW(EXP_W), .KW(KW)) u_exp_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .e     (e_unb),
    .k     (k_r),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = S_UNPACK;
      end
      S_UNPACK: state_nxt = special ? S_PACK : S_EDIV;
      S_EDIV:   if (div_done) state_nxt = S_TRIAL;
      S_TRIAL:  state_nxt = S_MUL;
      S_MUL:    if (mcnt == KW'(1)) state_nxt = S_CMP;
      S_CMP:    state_nxt = (idx == '0) ? S_PACK : S_TRIAL;
      S_PACK:   state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
`ifdef NROOT_FLAGS_EN
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          base_r <= base;
          k_r    <= root;
        end
        S_UNPACK: begin
          spec_r   <= special;
          spec_res <= spec_val;
`ifdef NROOT_FLAGS_EN
          inv_r    <= spec_inv;
`endif
        end
        S_EDIV: if (div_done) begin
          q_r  <= div_q;
          r_fx <= r_new;
          y    <= (MAN_W + 1)'(1) << MAN_W;
          idx  <= IW'(MAN_W - 1);
`ifdef NROOT_FLAGS_EN
          eq_r <= (r_new == (AW'(1) << FW));
`endif
        end
        S_TRIAL: begin
          trial <= y | bitmask;
          acc   <= AW'({y | bitmask, {GUARD{1'b0}}});
          mcnt  <= k_r - KW'(1);
        end
        S_MUL: begin
          // Once above R the candidate is rejected anyway; pin acc at full scale.
          acc  <= sat ? '1 : prod_sh[AW-1:0];
          mcnt <= mcnt - KW'(1);
        end
        S_CMP: begin
          if (acc <= r_fx) begin
            y <= trial;
`ifdef NROOT_FLAGS_EN
            eq_r <= (acc == r_fx);
`endif
          end
          idx <= idx - IW'(1);
        end
        S_PACK: begin
          out <= spec_r ? spec_res : {base_r[W-1], e_out, y[MAN_W-1:0]};
`ifdef NROOT_FLAGS_EN
          out_invalid <= spec_r && inv_r;
          out_inexact <= !spec_r && !eq_r;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nroot_seq_fp.sv
// tb/tb_nroot_seq_fp.sv - scoreboard bench for nroot_seq_fp in FP32 format
module tb_nroot_seq_fp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] base = '0;
  logic [3:0]  root = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out;
`ifdef NROOT_FLAGS_EN
  logic        out_invalid, out_inexact;
`endif

  always #5 clk = ~clk;

  nroot_seq_fp #(.EXP_W(8), .MAN_W(23), .MAX_ROOT(8), .GUARD(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .base       (base),
    .root       (root),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
`ifdef NROOT_FLAGS_EN
    .out_invalid(out_invalid),
    .out_inexact(out_inexact),
`endif
    .busy       (busy)
  );

  typedef struct {
    logic [31:0] want;
    bit          tol;
    int          lat;
    bit          inv;
    bit          inx;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic send(input logic [31:0] b, input logic [3:0] k);
    @(negedge clk);
    base = b;
    root = k;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic do_op(input string name, input logic [31:0] b, input logic [3:0] k,
                       input logic [31:0] want, input bit tol, input bit spec,
                       input bit inv, input bit inx, input int hold);
    exp_t e;
    exp_t g;
    int   cyc;
    e.want = want;
    e.tol  = tol;
    e.lat  = spec ? 2 : 1 + (8 + 2) + 23 * (int'(k) + 1) + 1;
    e.inv  = inv;
    e.inx  = inx;
    sb.push_back(e);
    send(b, k);
    wait_out(cyc);
    check({name, "_valid"}, out_valid, 1);
    g = sb.pop_front();
    check({name, "_latency"}, cyc, g.lat);
    if (g.tol)
      check({name, "_out"}, out, (out == g.want - 32'd1) ? g.want - 32'd1 : g.want);
    else
      check({name, "_out"}, out, g.want);
`ifdef NROOT_FLAGS_EN
    check({name, "_invalid"}, out_invalid, g.inv);
    check({name, "_inexact"}, out_inexact, g.inx);
`endif
    for (int i = 0; i < hold; i++) begin
      base = 32'h42800000;
      root = 4'd2;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check({name, "_hold_out"}, out, g.want);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    exp_t dropped;
    exp_t e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b0;

    do_op("cube27",    32'h41D80000, 4'd3, 32'h40400000, 0, 0, 0, 0, 5);
    do_op("neg8",      32'hC1000000, 4'd3, 32'hC0000000, 0, 0, 0, 0, 0);
    do_op("eighth",    32'h3E000000, 4'd3, 32'h3F000000, 0, 0, 0, 0, 0);
    do_op("sqrt2",     32'h40000000, 4'd2, 32'h3FB504F3, 1, 0, 0, 1, 0);
    do_op("quarter",   32'h3E800000, 4'd3, 32'h3F214517, 1, 0, 0, 1, 0);
    do_op("root6_64",  32'h42800000, 4'd6, 32'h40000000, 0, 0, 0, 0, 0);
    do_op("neg32_k5",  32'hC2000000, 4'd5, 32'hC0000000, 0, 0, 0, 0, 0);
    do_op("neg4_k2",   32'hC0800000, 4'd2, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    do_op("k0",        32'h40000000, 4'd0, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    do_op("k9",        32'h40000000, 4'd9, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    do_op("pinf_k5",   32'h7F800000, 4'd5, 32'h7F800000, 0, 1, 0, 0, 0);
    do_op("ninf_k3",   32'hFF800000, 4'd3, 32'hFF800000, 0, 1, 0, 0, 0);
    do_op("ninf_k2",   32'hFF800000, 4'd2, 32'h7FFFFFFF, 0, 1, 1, 0, 0);
    do_op("nzero_k3",  32'h80000000, 4'd3, 32'h80000000, 0, 1, 0, 0, 0);
    do_op("nzero_k2",  32'h80000000, 4'd2, 32'h00000000, 0, 1, 0, 0, 0);
    do_op("qnan",      32'h7FC00000, 4'd2, 32'h7FFFFFFF, 0, 1, 0, 0, 0);
    do_op("k1",        32'h40A00000, 4'd1, 32'h40A00000, 0, 1, 0, 0, 0);
    do_op("subnormal", 32'h00000001, 4'd3, 32'h00000000, 0, 1, 0, 0, 0);

    e.want = 32'h40400000;
    e.tol  = 0;
    e.lat  = 104;
    e.inv  = 0;
    e.inx  = 0;
    sb.push_back(e);
    send(32'h41D80000, 4'd3);
    repeat (49) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    dropped = sb.pop_front();
    check("abort_sb_empty", sb.size(), 0);

    do_op("after_abort", 32'h41D80000, 4'd3, 32'h40400000, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
